// File: rtl/hack_bus_pkg.sv
// Shared widths, state encoding and a one-hot helper for the 8-way word-path arbiter.
package hack_bus_pkg;

   localparam int NUM_PORTS = 8;
   localparam int SEL_W     = 3;
   localparam int WORD_W    = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NUM_PORTS-1:0] onehot8(input logic [SEL_W-1:0] idx);
      return NUM_PORTS'(1) << idx;
   endfunction

endpackage

// File: rtl/Mux8Way16.sv
// Existing 8-way 16-bit word multiplexer used as the arbiter datapath.
module Mux8Way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [15:0] e,
   input  logic [15:0] f,
   input  logic [15:0] g,
   input  logic [15:0] h,
   input  logic [2:0]  sel,
   output logic [15:0] out
);

   always_comb begin
      case (sel)
         3'd0:    out = a;
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         default: out = h;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first requester at or after base, wrapping mod 8.
module rr_pick8
   import hack_bus_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SEL_W-1:0]     base,
   output logic [SEL_W-1:0]     idx,
   output logic                 any
);

   logic [SEL_W-1:0] w_cand;

   // Scan from farthest offset down so the nearest requester is written last.
   always_comb begin
      idx    = base;
      w_cand = base;
      any    = |req;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         w_cand = base + SEL_W'(i);
         if (req[w_cand]) begin
            idx = w_cand;
         end
      end
   end

endmodule

// File: rtl/mux8way16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit word path among 8 requesters,
// with bursts capped at MAX_HOLD beats and a valid/ready consumer port.
//
//  state | meaning
//  IDLE  | no grant outstanding, waiting for any req
//  GRANT | gnt/sel point at one requester, beats flow on fire
module mux8way16_rr_arbiter
   import hack_bus_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_PORTS-1:0]        req,
   input  logic [NUM_PORTS*WORD_W-1:0] in_bus,
   output logic [NUM_PORTS-1:0]        gnt,
   output logic [NUM_PORTS-1:0]        ack,
   output logic [SEL_W-1:0]            sel,
   output logic [WORD_W-1:0]           out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

   state_t                 r_state;
   logic [SEL_W-1:0]       r_sel;
   logic [SEL_W-1:0]       r_ptr;
   logic [NUM_PORTS-1:0]   r_gnt;
   logic [3:0]             r_beat_cnt;

   logic [SEL_W-1:0]       w_pick_base;
   logic [SEL_W-1:0]       w_pick_idx;
   logic                   w_pick_any;
   logic [WORD_W-1:0]      w_mux_out;
   logic                   w_out_valid;
   logic                   w_fire;
   logic                   w_release;

   // One picker serves both the fresh grant from IDLE and the re-grant on release.
   assign w_pick_base = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

   rr_pick8 u_pick (
      .req  (req),
      .base (w_pick_base),
      .idx  (w_pick_idx),
      .any  (w_pick_any)
   );

   Mux8Way16 u_mux (
      .a   (in_bus[0*WORD_W +: WORD_W]),
      .b   (in_bus[1*WORD_W +: WORD_W]),
      .c   (in_bus[2*WORD_W +: WORD_W]),
      .d   (in_bus[3*WORD_W +: WORD_W]),
      .e   (in_bus[4*WORD_W +: WORD_W]),
      .f   (in_bus[5*WORD_W +: WORD_W]),
      .g   (in_bus[6*WORD_W +: WORD_W]),
      .h   (in_bus[7*WORD_W +: WORD_W]),
      .sel (r_sel),
      .out (w_mux_out)
   );

   assign w_out_valid = (r_state == GRANT) && req[r_sel];
   assign w_fire      = w_out_valid && out_ready;
   assign w_release   = !req[r_sel] || (w_fire && (r_beat_cnt == LAST_BEAT));

   assign gnt       = r_gnt;
   assign sel       = r_sel;
   assign ack       = r_gnt & {NUM_PORTS{w_fire}};
   assign out       = w_out_valid ? w_mux_out : '0;
   assign out_valid = w_out_valid;
   assign busy      = (r_state == GRANT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_sel      <= w_pick_idx;
                  r_gnt      <= onehot8(w_pick_idx);
                  r_beat_cnt <= '0;
                  r_state    <= GRANT;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_ptr <= r_sel + SEL_W'(1);
                  if (w_pick_any) begin
                     r_sel      <= w_pick_idx;
                     r_gnt      <= onehot8(w_pick_idx);
                     r_beat_cnt <= '0;
                  end else begin
                     r_gnt      <= '0;
                     r_beat_cnt <= '0;
                     r_state    <= IDLE;
                  end
               end else if (w_fire) begin
                  r_beat_cnt <= r_beat_cnt + 4'd1;
               end
            end
            default: begin
               r_gnt   <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux8way16_rr_arbiter.sv
// Scenario bench for the round-robin word arbiter; transfers are scored against a queue.
module tb_mux8way16_rr_arbiter;

   logic          clk;
   logic          reset_n;
   logic [7:0]    req;
   logic [127:0]  in_bus;
   logic [7:0]    gnt;
   logic [7:0]    ack;
   logic [2:0]    sel;
   logic [15:0]   out;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   typedef struct packed {
      logic [2:0]  idx;
      logic [15:0] data;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        sb_e;
   logic [15:0] words [8];
   int          n_checks;
   int          n_errors;

   mux8way16_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .in_bus    (in_bus),
      .gnt       (gnt),
      .ack       (ack),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Consumer side: every acked word must be the next one the scenario expected.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && ack !== 8'h00) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_unexpected: ack=%h out=%h but no transfer expected", ack, out);
         end else begin
            sb_e = sb_q.pop_front();
            if (ack !== (8'h01 << sb_e.idx) || out !== sb_e.data) begin
               n_errors++;
               $display("FAIL sb_transfer: ack=%h out=%h expected ack=%h out=%h",
                        ack, out, 8'h01 << sb_e.idx, sb_e.data);
            end
         end
      end
   end

   task automatic push_exp(input int idx, input int count);
      for (int k = 0; k < count; k++) begin
         sb_q.push_back('{idx[2:0], words[idx]});
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic finish_test(input string name);
      #1 req = 8'h00;
      repeat (3) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL %s_drain: %0d expected transfers never acked, required 0", name, sb_q.size());
      end
      sb_q.delete();
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req       = 8'hff;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (gnt !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || out !== 16'h0000 ||
          ack !== 8'h00 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: gnt=%h sel=%0d valid=%b out=%h ack=%h busy=%b required all zero",
                  gnt, sel, out_valid, out, ack, busy);
      end
      req = 8'h00;
      #1 reset_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      @(posedge clk);
      #1 req = 8'h04; out_ready = 1'b1;
      push_exp(2, 8);
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if (gnt !== 8'h04 || sel !== 3'd2 || out !== 16'h1122 || ack !== 8'h04) begin
               n_errors++;
               $display("FAIL single_first: gnt=%h sel=%0d out=%h ack=%h required 04/2/1122/04",
                        gnt, sel, out, ack);
            end
         end
         if (c == 4) begin
            n_checks++;
            if (dut.r_beat_cnt !== 4'd3) begin
               n_errors++;
               $display("FAIL single_beat4: beat_cnt=%0d required 3", dut.r_beat_cnt);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (gnt !== 8'h04 || out_valid !== 1'b1 || dut.r_beat_cnt !== 4'd0) begin
               n_errors++;
               $display("FAIL single_regrant: gnt=%h valid=%b beat_cnt=%0d required 04/1/0",
                        gnt, out_valid, dut.r_beat_cnt);
            end
         end
      end
      @(posedge clk);
      finish_test("single");
   endtask

   task automatic test_all_rr();
      do_reset();
      @(posedge clk);
      #1 req = 8'hff; out_ready = 1'b1;
      for (int k = 0; k < 36; k++) begin
         push_exp((k / 4) % 8, 1);
      end
      for (int c = 0; c <= 36; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            n_checks++;
            if (sel !== 3'(((c - 1) / 4) % 8) || out_valid !== 1'b1) begin
               n_errors++;
               $display("FAIL all_rr_sel: cycle=%0d sel=%0d valid=%b required sel=%0d valid=1",
                        c, sel, out_valid, ((c - 1) / 4) % 8);
            end
         end
      end
      @(posedge clk);
      finish_test("all_rr");
   endtask

   task automatic test_backpressure();
      do_reset();
      @(posedge clk);
      #1 req = 8'h01; out_ready = 1'b0;
      push_exp(0, 4);
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            n_checks++;
            if (out_valid !== 1'b1 || out !== 16'haabb || ack !== 8'h00 || dut.r_beat_cnt !== 4'd0) begin
               n_errors++;
               $display("FAIL backpressure_hold: cycle=%0d valid=%b out=%h ack=%h beat_cnt=%0d required 1/aabb/00/0",
                        c, out_valid, out, ack, dut.r_beat_cnt);
            end
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(negedge clk);
      @(posedge clk);
      finish_test("backpressure");
   endtask

   task automatic test_withdraw();
      do_reset();
      @(posedge clk);
      #1 req = 8'h22; out_ready = 1'b1;
      push_exp(1, 2);
      push_exp(5, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 req = 8'h20;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || ack !== 8'h00) begin
         n_errors++;
         $display("FAIL withdraw_gap: valid=%b ack=%h required 0/00", out_valid, ack);
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== 8'h20 || out !== 16'h7788 || dut.r_ptr !== 3'd2) begin
         n_errors++;
         $display("FAIL withdraw_next: gnt=%h out=%h ptr=%0d required 20/7788/2", gnt, out, dut.r_ptr);
      end
      @(posedge clk);
      finish_test("withdraw");
   endtask

   task automatic test_wrap();
      do_reset();
      @(posedge clk);
      #1 req = 8'h40; out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 req = 8'h00;
      @(posedge clk);
      #1 req = 8'h81; out_ready = 1'b1;
      push_exp(7, 4);
      push_exp(0, 4);
      @(negedge clk);
      n_checks++;
      if (dut.r_ptr !== 3'd7 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_setup: ptr=%0d busy=%b required 7/0", dut.r_ptr, busy);
      end
      for (int c = 4; c <= 11; c++) begin
         @(negedge clk);
         if (c == 4) begin
            n_checks++;
            if (gnt !== 8'h80 || out_valid !== 1'b1 || out !== 16'h0000) begin
               n_errors++;
               $display("FAIL wrap_first: gnt=%h valid=%b out=%h required 80/1/0000", gnt, out_valid, out);
            end
         end
         if (c == 8) begin
            n_checks++;
            if (gnt !== 8'h01 || out !== 16'haabb) begin
               n_errors++;
               $display("FAIL wrap_second: gnt=%h out=%h required 01/aabb", gnt, out);
            end
         end
      end
      @(posedge clk);
      finish_test("wrap");
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      @(posedge clk);
      #1 req = 8'h08; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (gnt !== 8'h08) begin
         n_errors++;
         $display("FAIL midreset_pre: gnt=%h required 08", gnt);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (gnt !== 8'h00 || out_valid !== 1'b0 || out !== 16'h0000 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL midreset_async: gnt=%h valid=%b out=%h busy=%b required 00/0/0000/0",
                  gnt, out_valid, out, busy);
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (gnt !== 8'h00) begin
         n_errors++;
         $display("FAIL midreset_release: gnt=%h required 00", gnt);
      end
      @(negedge clk);
      n_checks++;
      if (gnt !== 8'h08 || out_valid !== 1'b1 || out !== 16'h3344) begin
         n_errors++;
         $display("FAIL midreset_regrant: gnt=%h valid=%b out=%h required 08/1/3344", gnt, out_valid, out);
      end
      @(posedge clk);
      finish_test("midreset");
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      words[0] = 16'haabb; words[1] = 16'hccdd; words[2] = 16'h1122; words[3] = 16'h3344;
      words[4] = 16'h5566; words[5] = 16'h7788; words[6] = 16'h9900; words[7] = 16'h0000;
      in_bus = {words[7], words[6], words[5], words[4], words[3], words[2], words[1], words[0]};
      reset_n   = 1'b0;
      req       = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_all_rr();
      test_backpressure();
      test_withdraw();
      test_wrap();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mux8way16_rr_arbiter.md
Name: mux8way16_rr_arbiter

Overview:
Round-robin arbiter that shares one 16-bit output word path among 8 requesters. It registers a 3-bit select that drives an internal Mux8Way16 instance. It presents the selected word to a single consumer through a valid/ready handshake. Grants are held for bursts of up to MAX_HOLD beats, then forcibly rotated, so no requester can starve another.

Parameters:
- MAX_HOLD, 4: maximum beats per grant before forced rotation; legal range 1..15.
- WORD_W, 16: data width. Fixed by the Mux8Way16 instance; not overridable.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req, input, 8: req[i]=1 means requester i has a word pending.
- in_bus, input, 128: word i on in_bus[16*i+15:16*i].
- gnt, output, 8: one-hot grant, registered.
- ack, output, 8: ack[i]=1 means word i was consumed this cycle.
- sel, output, 3: registered select, also feeds the Mux8Way16 instance.
- out, output, 16: selected word; 16'h0000 when out_valid=0.
- out_valid, output, 1: word on out is valid.
- out_ready, input, 1: consumer accepts the word.
- busy, output, 1: 1 while in state GRANT.

Behaviour:
- Reset (async, while reset_n=0):
  - state=IDLE; sel=0; gnt=0; ptr=0; beat_cnt=0.
  - Outputs: out_valid=0, out=0, ack=0, busy=0.
  - Asserting reset mid-burst drops gnt immediately; no ack is generated.
- Combinational outputs:
  - out_valid = (state==GRANT) & req[sel].
  - fire = out_valid & out_ready.
  - ack = gnt & {8{fire}}.
  - out = out_valid ? in_bus word[sel] : 0.
  - busy = (state==GRANT).
- Pick function: pick(base) returns the first index with req set, scanning base, base+1, ..., base+7, mod 8.
- IDLE:
  - If req!=0: sel<=pick(ptr); gnt<=onehot(sel); beat_cnt<=0; go to GRANT.
  - Latency: req rising in cycle 0 gives gnt and out_valid in cycle 1.
  - If req==0: remain in IDLE.
- GRANT, release condition: release = !req[sel] | (fire & beat_cnt==MAX_HOLD-1).
- GRANT, on release:
  - ptr<=sel+1 (3-bit wrap, so 7 goes to 0).
  - If req!=0: immediately re-grant pick(sel+1) with beat_cnt<=0 and stay in GRANT. There is no idle bubble.
  - The same requester may be re-picked if it is the only one requesting.
  - Otherwise: gnt<=0 and go to IDLE.
- GRANT, no release: if fire, beat_cnt<=beat_cnt+1; otherwise hold.
- A requester drops req the cycle after its final ack. The withdrawal is seen as !req[sel] and causes release.
- Withdrawal without ack (req[sel] falls while out_ready=0):
  - out_valid falls that cycle; no transfer occurs.
  - Release happens at the next edge.
- out_ready held low: grant holds indefinitely; beat_cnt does not advance; out stays stable.
- MAX_HOLD=1 gives strict per-beat round-robin.
- beat_cnt is 4 bits wide and never exceeds MAX_HOLD-1.
- Simultaneous requests: the lowest index at or after ptr wins. ptr only changes on release.
- Invariants:
  - gnt is one-hot or zero.
  - gnt!=0 if and only if state==GRANT.
  - ack is a subset of gnt.

Decomposition:
- Package hack_bus_pkg holds:
  - NUM_PORTS=8, SEL_W=3, WORD_W=16.
  - The state enum {IDLE, GRANT}.
- Sub-module rr_pick8: combinational rotating-priority picker. Inputs req[7:0] and base[2:0]; outputs idx[2:0] and any.
- The existing Mux8Way16 is instantiated for the datapath; it is not reimplemented.

Test Plan:
1. Single requester, no backpressure:
   - Stimulus: in_bus words 0..7 = aabb, ccdd, 1122, 3344, 5566, 7788, 9900, 0000. req=8'b0000_0100 from cycle 0, out_ready=1.
   - Response: gnt=0x04, sel=2 and out=16'h1122 from cycle 1. ack[2] on cycles 1-4; release at the edge ending cycle 4 (after the 4th beat); immediate re-grant to 2 with no bubble.
2. All 8 requesting, MAX_HOLD=4, out_ready=1:
   - Response: sel sequence 0,1,2,...,7,0, each held exactly 4 cycles.
   - out runs aabb x4, ccdd x4, 1122 x4, ...; no gaps.
3. Backpressure:
   - Stimulus: req=8'h01 with out_ready=0 for 5 cycles, then 1.
   - Response: out_valid=1 and out=16'haabb held stable, ack=0, beat_cnt=0 throughout; then 4 acks follow.
4. Early withdrawal:
   - Stimulus: req=8'h22; requester 1 drops req after its 2nd ack.
   - Response: the next edge grants 5 (gnt=0x20, out=16'h7788); ptr becomes 2.
5. Wrap-around:
   - Stimulus: ptr=7 with req=8'h81.
   - Response: 7 is granted first (out=16'h0000, out_valid=1), then 0 (out=16'haabb).
6. Reset mid-burst:
   - Stimulus: reset_n pulled low asynchronously during a grant to 3.
   - Response: gnt=0, out_valid=0 and out=0 without waiting for a clock edge. After release with req=8'h08, 3 is re-granted one cycle later.
